// File: rtl/be8_ctrl_pkg.sv
// rtl/be8_ctrl_pkg.sv - shared constants for the 8-bit bus CPU control unit
// Opcodes, control word bit positions, idle word and microstep encoding.
package be8_ctrl_pkg;

   localparam int OPCODE_W = 4;
   localparam int CTRL_W   = 16;
   localparam int STEP_W   = 3;

   localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
   localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
   localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
   localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

   localparam int HLT  = 0;
   localparam int MI_N = 1;
   localparam int RI_N = 2;
   localparam int RO_N = 3;
   localparam int IO_N = 4;
   localparam int II_N = 5;
   localparam int AI_N = 6;
   localparam int AO_N = 7;
   localparam int EO_N = 8;
   localparam int SU   = 9;
   localparam int BI_N = 10;
   localparam int OI_N = 11;
   localparam int CE   = 12;
   localparam int CO_N = 13;
   localparam int J_N  = 14;
   localparam int FI_N = 15;

   // Every active-low strobe released, SU/CE/HLT deasserted.
   localparam logic [CTRL_W-1:0] CTRL_IDLE = 16'hEDFE;

   localparam logic [STEP_W-1:0] T0 = 3'd0;
   localparam logic [STEP_W-1:0] T1 = 3'd1;
   localparam logic [STEP_W-1:0] T2 = 3'd2;
   localparam logic [STEP_W-1:0] T3 = 3'd3;
   localparam logic [STEP_W-1:0] T4 = 3'd4;

   // Final microstep of each opcode; undefined opcodes behave as NOP.
   function automatic logic [STEP_W-1:0] last_step(input logic [OPCODE_W-1:0] op);
      case (op)
         OP_LDA, OP_STA:                                  last_step = T3;
         OP_ADD, OP_SUB:                                  last_step = T4;
         OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:    last_step = T2;
         default:                                         last_step = T1;
      endcase
   endfunction

endpackage

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational microcode table
// Maps opcode, microstep and ALU flags to a raw control word and end-of-instruction flag.
module microcode_rom
   import be8_ctrl_pkg::*;
(
   input  logic [OPCODE_W-1:0] i_opcode,
   input  logic [STEP_W-1:0]   i_step,
   input  logic                i_flag_c,
   input  logic                i_flag_z,
   output logic [CTRL_W-1:0]   o_ctrl,
   output logic                o_last_step
);

   // >= keeps any out-of-range step terminating the instruction.
   assign o_last_step = (i_step >= last_step(i_opcode));

   always_comb begin
      o_ctrl = CTRL_IDLE;
      case (i_step)
         T0: begin
            o_ctrl[CO_N] = 1'b0;
            o_ctrl[MI_N] = 1'b0;
         end
         T1: begin
            o_ctrl[RO_N] = 1'b0;
            o_ctrl[II_N] = 1'b0;
            o_ctrl[CE]   = 1'b1;
         end
         T2: begin
            case (i_opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  o_ctrl[IO_N] = 1'b0;
                  o_ctrl[MI_N] = 1'b0;
               end
               OP_LDI: begin
                  o_ctrl[IO_N] = 1'b0;
                  o_ctrl[AI_N] = 1'b0;
               end
               OP_JMP: begin
                  o_ctrl[IO_N] = 1'b0;
                  o_ctrl[J_N]  = 1'b0;
               end
               OP_JC: begin
                  o_ctrl[IO_N] = 1'b0;
                  o_ctrl[J_N]  = ~i_flag_c;
               end
               OP_JZ: begin
                  o_ctrl[IO_N] = 1'b0;
                  o_ctrl[J_N]  = ~i_flag_z;
               end
               OP_OUT: begin
                  o_ctrl[AO_N] = 1'b0;
                  o_ctrl[OI_N] = 1'b0;
               end
               OP_HLT:  o_ctrl[HLT] = 1'b1;
               default: ;
            endcase
         end
         T3: begin
            case (i_opcode)
               OP_LDA: begin
                  o_ctrl[RO_N] = 1'b0;
                  o_ctrl[AI_N] = 1'b0;
               end
               OP_ADD, OP_SUB: begin
                  o_ctrl[RO_N] = 1'b0;
                  o_ctrl[BI_N] = 1'b0;
               end
               OP_STA: begin
                  o_ctrl[AO_N] = 1'b0;
                  o_ctrl[RI_N] = 1'b0;
               end
               default: ;
            endcase
         end
         T4: begin
            if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
               o_ctrl[EO_N] = 1'b0;
               o_ctrl[AI_N] = 1'b0;
               o_ctrl[FI_N] = 1'b0;
               o_ctrl[SU]   = (i_opcode == OP_SUB);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microstep counter, halt state and strobe gating
// Drives the datapath control word from the microcode table each cycle.
module control_sequencer
   import be8_ctrl_pkg::*;
(
   input  logic                CLK,
   input  logic                RESETn,
   input  logic                STEP_EN,
   input  logic [OPCODE_W-1:0] OPCODE,
   input  logic                FLAG_C,
   input  logic                FLAG_Z,
   output logic [CTRL_W-1:0]   CTRL,
   output logic [STEP_W-1:0]   TSTATE,
   output logic                HALTED
);

   logic [STEP_W-1:0] r_step;
   logic              r_halted;
   logic [CTRL_W-1:0] w_raw_ctrl;
   logic              w_last_step;
   logic              w_advance;

   microcode_rom u_rom (
      .i_opcode    (OPCODE),
      .i_step      (r_step),
      .i_flag_c    (FLAG_C),
      .i_flag_z    (FLAG_Z),
      .o_ctrl      (w_raw_ctrl),
      .o_last_step (w_last_step)
   );

   assign w_advance = STEP_EN && !r_halted;

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_step   <= T0;
         r_halted <= 1'b0;
      end else if (w_advance) begin
         if (w_last_step) begin
            r_step <= T0;
            // The HLT bit only appears in HLT's final step.
            if (w_raw_ctrl[HLT])
               r_halted <= 1'b1;
         end else begin
            r_step <= r_step + 3'd1;
         end
      end
   end

   // Strobes must stay released whenever the counter is not genuinely advancing.
   assign CTRL   = (RESETn && w_advance) ? w_raw_ctrl : CTRL_IDLE;
   assign TSTATE = r_step;
   assign HALTED = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed bench for control_sequencer
module tb_control_sequencer;

   logic        CLK = 1'b0;
   logic        RESETn;
   logic        STEP_EN;
   logic [3:0]  OPCODE;
   logic        FLAG_C;
   logic        FLAG_Z;
   logic [15:0] CTRL;
   logic [2:0]  TSTATE;
   logic        HALTED;

   int n_vec = 0;
   int n_err = 0;

   control_sequencer dut (
      .CLK     (CLK),
      .RESETn  (RESETn),
      .STEP_EN (STEP_EN),
      .OPCODE  (OPCODE),
      .FLAG_C  (FLAG_C),
      .FLAG_Z  (FLAG_Z),
      .CTRL    (CTRL),
      .TSTATE  (TSTATE),
      .HALTED  (HALTED)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESETn = 1'b0; STEP_EN = 1'b1; OPCODE = 4'h0; FLAG_C = 1'b0; FLAG_Z = 1'b0;
      tick(); tick();
      n_vec++;
      if (TSTATE !== 3'd0) begin n_err++; $display("FAIL reset_tstate got %0d want 0", TSTATE); end
      n_vec++;
      if (HALTED !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", HALTED); end
      n_vec++;
      if (CTRL !== 16'hEDFE) begin n_err++; $display("FAIL reset_ctrl got %h want edfe", CTRL); end
      RESETn = 1'b1;
      #1;
   endtask

   task automatic test_nop();
      logic [15:0] exp_c;
      OPCODE = 4'h0;
      for (int i = 0; i < 4; i++) begin
         exp_c = (i % 2 == 0) ? 16'hCDFC : 16'hFDD6;
         n_vec++;
         if (TSTATE !== 3'(i % 2)) begin n_err++; $display("FAIL nop_tstate[%0d] got %0d want %0d", i, TSTATE, i % 2); end
         n_vec++;
         if (CTRL !== exp_c) begin n_err++; $display("FAIL nop_ctrl[%0d] got %h want %h", i, CTRL, exp_c); end
         n_vec++;
         if (HALTED !== 1'b0) begin n_err++; $display("FAIL nop_halted[%0d] got %b want 0", i, HALTED); end
         tick();
      end
   endtask

   // Runs one instruction from T0; unused entries beyond the last step are ignored.
   task automatic test_instr(input string name, input logic [3:0] op, input int nsteps,
                             input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
      logic [15:0] exp_c [5];
      exp_c[0] = 16'hCDFC; exp_c[1] = 16'hFDD6; exp_c[2] = e2; exp_c[3] = e3; exp_c[4] = e4;
      OPCODE = op;
      #1;
      for (int i = 0; i < nsteps; i++) begin
         n_vec++;
         if (TSTATE !== 3'(i)) begin n_err++; $display("FAIL %s_tstate[%0d] got %0d want %0d", name, i, TSTATE, i); end
         n_vec++;
         if (CTRL !== exp_c[i]) begin n_err++; $display("FAIL %s_ctrl[%0d] got %h want %h", name, i, CTRL, exp_c[i]); end
         tick();
      end
      n_vec++;
      if (TSTATE !== 3'd0) begin n_err++; $display("FAIL %s_wrap got %0d want 0", name, TSTATE); end
   endtask

   task automatic test_jump(input string name, input logic [3:0] op, input logic c, input logic z,
                            input logic [15:0] exp_t2);
      OPCODE = op; FLAG_C = c; FLAG_Z = z;
      tick(); tick();
      n_vec++;
      if (TSTATE !== 3'd2) begin n_err++; $display("FAIL %s_t2 got %0d want 2", name, TSTATE); end
      n_vec++;
      if (CTRL !== exp_t2) begin n_err++; $display("FAIL %s_ctrl got %h want %h", name, CTRL, exp_t2); end
      tick();
      n_vec++;
      if (TSTATE !== 3'd0) begin n_err++; $display("FAIL %s_next got %0d want 0", name, TSTATE); end
      FLAG_C = 1'b0; FLAG_Z = 1'b0;
   endtask

   task automatic test_halt();
      OPCODE = 4'hF;
      tick(); tick();
      n_vec++;
      if (CTRL !== 16'hEDFF) begin n_err++; $display("FAIL hlt_t2_ctrl got %h want edff", CTRL); end
      n_vec++;
      if (HALTED !== 1'b0) begin n_err++; $display("FAIL hlt_t2_halted got %b want 0", HALTED); end
      tick();
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if (HALTED !== 1'b1 || TSTATE !== 3'd0 || CTRL !== 16'hEDFE) begin
            n_err++;
            $display("FAIL hlt_hold[%0d] got halted=%b ts=%0d ctrl=%h want 1/0/edfe", i, HALTED, TSTATE, CTRL);
         end
         tick();
      end
      RESETn = 1'b0;
      tick();
      RESETn = 1'b1;
      OPCODE = 4'h0;
      #1;
      n_vec++;
      if (HALTED !== 1'b0 || TSTATE !== 3'd0) begin
         n_err++; $display("FAIL hlt_reset got halted=%b ts=%0d want 0/0", HALTED, TSTATE);
      end
      n_vec++;
      if (CTRL !== 16'hCDFC) begin n_err++; $display("FAIL hlt_reset_ctrl got %h want cdfc", CTRL); end
   endtask

   task automatic test_stall();
      OPCODE = 4'h2;
      tick(); tick(); tick();
      STEP_EN = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (TSTATE !== 3'd3 || CTRL !== 16'hEDFE) begin
            n_err++; $display("FAIL stall[%0d] got ts=%0d ctrl=%h want 3/edfe", i, TSTATE, CTRL);
         end
         tick();
      end
      STEP_EN = 1'b1;
      #1;
      n_vec++;
      if (TSTATE !== 3'd3 || CTRL !== 16'hE9F6) begin
         n_err++; $display("FAIL stall_resume got ts=%0d ctrl=%h want 3/e9f6", TSTATE, CTRL);
      end
      tick();
      n_vec++;
      if (TSTATE !== 3'd4 || CTRL !== 16'h6CBE) begin
         n_err++; $display("FAIL stall_t4 got ts=%0d ctrl=%h want 4/6cbe", TSTATE, CTRL);
      end
      tick();
      n_vec++;
      if (TSTATE !== 3'd0) begin n_err++; $display("FAIL stall_wrap got %0d want 0", TSTATE); end
   endtask

   task automatic test_reset_mid();
      OPCODE = 4'h1;
      tick(); tick(); tick();
      n_vec++;
      if (TSTATE !== 3'd3 || CTRL !== 16'hEDB6) begin
         n_err++; $display("FAIL lda_t3 got ts=%0d ctrl=%h want 3/edb6", TSTATE, CTRL);
      end
      RESETn = 1'b0;
      #1;
      n_vec++;
      if (CTRL !== 16'hEDFE) begin n_err++; $display("FAIL rst_mid_ctrl got %h want edfe", CTRL); end
      tick();
      n_vec++;
      if (TSTATE !== 3'd0 || CTRL !== 16'hEDFE) begin
         n_err++; $display("FAIL rst_mid_low got ts=%0d ctrl=%h want 0/edfe", TSTATE, CTRL);
      end
      RESETn = 1'b1;
      #1;
      n_vec++;
      if (TSTATE !== 3'd0 || CTRL !== 16'hCDFC) begin
         n_err++; $display("FAIL rst_mid_release got ts=%0d ctrl=%h want 0/cdfc", TSTATE, CTRL);
      end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_instr("add", 4'h2, 5, 16'hEDEC, 16'hE9F6, 16'h6CBE);
      test_instr("sub", 4'h3, 5, 16'hEDEC, 16'hE9F6, 16'h6EBE);
      test_instr("lda", 4'h1, 4, 16'hEDEC, 16'hEDB6, 16'hEDFE);
      test_instr("sta", 4'h4, 4, 16'hEDEC, 16'hED7A, 16'hEDFE);
      test_instr("ldi", 4'h5, 3, 16'hEDAE, 16'hEDFE, 16'hEDFE);
      test_instr("out", 4'hE, 3, 16'hE57E, 16'hEDFE, 16'hEDFE);
      test_instr("undef", 4'hA, 2, 16'hEDFE, 16'hEDFE, 16'hEDFE);
      test_jump("jc_taken", 4'h7, 1'b1, 1'b0, 16'hADEE);
      test_jump("jc_not", 4'h7, 1'b0, 1'b1, 16'hEDEE);
      test_jump("jz_taken", 4'h8, 1'b0, 1'b1, 16'hADEE);
      test_jump("jmp", 4'h6, 1'b0, 1'b0, 16'hADEE);
      test_stall();
      test_reset_mid();
      test_halt();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
